timer: RTL

- Memory-mapped DIV/TIMA/TMA/TAC timer peripheral on the CPU bus at FF04-FF07.
- Sits directly downstream of the gameboy top-level CPU bus and decodes the same a/dout/din/rd/wr signals the CPU drives.
- Raises the timer interrupt request consumed by the interrupt controller.
- Clocked from the 4.19 MHz system clock.

---
 rtl/timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer peripheral on the CPU bus, with the DMG falling-edge tick quirks
// and the delayed TMA reload after a TIMA overflow.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  output logic        hit,
  output logic        int_tim_req,
  input  logic        int_tim_ack
);

  typedef enum logic [1:0] {StRun, StOvf, StReload} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  tima_q;
  logic [7:0]  tma_q;
  logic [2:0]  tac_q;
  logic [1:0]  ovf_cnt_q;
  logic        t_q;
  logic        int_q;

  logic [15:0] off;
  logic [7:0]  rdata;
  logic        sel;
  logic        t;
  logic        tick;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  assign off = a - BASE_ADDR;
  assign hit = (off < 16'd4);

  assign wr_div  = wr && hit && (off[1:0] == 2'd0);
  assign wr_tima = wr && hit && (off[1:0] == 2'd1);
  assign wr_tma  = wr && hit && (off[1:0] == 2'd2);
  assign wr_tac  = wr && hit && (off[1:0] == 2'd3);

  always_comb begin
    rdata = 8'hFF;
    unique case (off[1:0])
      2'd0:    rdata = cnt_q[15:8];
      2'd1:    rdata = tima_q;
      2'd2:    rdata = tma_q;
      default: rdata = {5'b11111, tac_q};
    endcase
    dout = (rd && hit) ? rdata : 8'hFF;
  end

  always_comb begin
    sel = 1'b0;
    unique case (tac_q[1:0])
      2'b00:   sel = cnt_q[9];
      2'b01:   sel = cnt_q[3];
      2'b10:   sel = cnt_q[5];
      default: sel = cnt_q[7];
    endcase
  end

  // t is derived from the registered cnt/TAC, so a DIV or TAC write that pulls t low
  // produces a falling edge one clock later, just like a natural tick.
  assign t    = tac_q[2] & sel;
  assign tick = t_q & ~t;

  assign int_tim_req = int_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= 16'h0000;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      ovf_cnt_q <= 2'd0;
      t_q       <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      cnt_q <= wr_div ? 16'h0000 : cnt_q + 16'd1;
      t_q   <= t;
      if (wr_tma) tma_q <= din;
      if (wr_tac) tac_q <= din[2:0];
      if (int_tim_ack) int_q <= 1'b0;

      unique case (state_q)
        StRun: begin
          if (wr_tima) begin
            tima_q <= din;
          end else if (tick) begin
            if (tima_q == 8'hFF) begin
              tima_q    <= 8'h00;
              ovf_cnt_q <= 2'd2;
              state_q   <= StOvf;
            end else begin
              tima_q <= tima_q + 8'd1;
            end
          end
        end
        StOvf: begin
          // A TIMA write here cancels the pending reload and its interrupt.
          if (wr_tima) begin
            tima_q  <= din;
            state_q <= StRun;
          end else if (ovf_cnt_q == 2'd0) begin
            state_q <= StReload;
          end else begin
            ovf_cnt_q <= ovf_cnt_q - 2'd1;
          end
        end
        StReload: begin
          tima_q  <= wr_tma ? din : tma_q;
          int_q   <= 1'b1;
          state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
